// File: rtl/latch_close_capture.sv
// ---------------------------------------------------------------------------
// latch_close_capture
//
// Watches an upstream transparent latch and captures its output value at the
// moment it closes. A close is a falling edge of the latch enable: the enable
// is registered each cycle, and a close is seen when the registered copy is 1
// and the live enable is 0. Each captured value is pushed into a small FIFO
// that a downstream consumer drains with a valid/ready handshake.
//
// When the FIFO is full, a capture is still accepted if the consumer pops on
// the same edge. Otherwise the capture is dropped and the FIFO contents are
// left untouched.
//
// Parameters
//   WIDTH      latch data width in bits
//   DEPTH      number of FIFO entries (power of two, >= 2)
//
// Ports
//   ck         clock; all state updates on its rising edge
//   rst        synchronous active-high reset
//   le         upstream latch enable (transparent when 1)
//   q          upstream latch output
//   out_valid  FIFO head holds data (equals !empty)
//   out_ready  consumer accepts the head on this edge
//   out_data   FIFO head value; don't-care while empty
//   full       FIFO holds DEPTH entries
//   empty      FIFO holds no entries
//   ovf_cnt    saturating count of dropped captures
//
// Configuration
//   LATCH_CLOSE_CAPTURE_OVF_CNT_EN  when defined, ovf_cnt counts drops and
//                                   saturates at 255; when undefined, ovf_cnt
//                                   is tied to 0 and no counter is built.
// ---------------------------------------------------------------------------
module latch_close_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             le,
  input  logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty,
  output logic [7:0]       ovf_cnt
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates "full" from "empty" when the index bits
  // of the read and write pointers are equal.
  typedef logic [AW:0] ptr_t;

  logic             le_d;
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic close_evt;
  logic pop;
  logic push;

  // Status comes only from the registered pointers, so there is no
  // combinational path from out_ready or le to out_valid, full or empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  // out_ready is ignored while empty, so the read pointer never moves then.
  assign close_evt = le_d && !le;
  assign pop       = out_valid && out_ready;
  assign push      = close_evt && (!full || pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  // le_d clears on reset, so an enable held high through reset release looks
  // like a rising edge, never a close; the first close must be a real 1->0.
  always_ff @(posedge ck) begin
    if (rst) begin
      le_d   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      le_d <= le;
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are live, so clearing the data would cost flops for nothing.
  // The write is gated by rst so a close coinciding with reset leaves no trace.
  always_ff @(posedge ck) begin
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= q;
  end

`ifdef LATCH_CLOSE_CAPTURE_OVF_CNT_EN
  logic       drop;
  logic [7:0] ovf_q;

  // A drop is a close that finds the FIFO full with no pop to make room.
  assign drop = close_evt && full && !pop;

  always_ff @(posedge ck) begin
    if (rst) begin
      ovf_q <= 8'd0;
    end else if (drop && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_latch_close_capture.sv
// ---------------------------------------------------------------------------
// tb_latch_close_capture
//
// Directed bench for latch_close_capture (WIDTH=8, DEPTH=4). A queue model
// tracks the FIFO contents from the input rules alone; a compare process
// checks every DUT output against that model shortly after each rising edge.
// Directed scenarios add literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_latch_close_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             ck = 1'b0;
  logic             rst = 1'b1;
  logic             le = 1'b1;
  logic [WIDTH-1:0] q = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             full;
  logic             empty;
  logic [7:0]       ovf_cnt;

  int checks = 0;
  int errors = 0;

  latch_close_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ck        (ck),
    .rst       (rst),
    .le        (le),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 ck = ~ck;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_fifo[$];
  logic             m_prev_le = 1'b0;
  int               m_drops = 0;
  bit               model_on = 1'b0;

  always @(posedge ck) begin
    if (rst) begin
      m_fifo.delete();
      m_prev_le = 1'b0;
      m_drops   = 0;
      model_on  = 1'b1;
    end else begin
      bit closing;
      closing = m_prev_le && !le;
      if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
      if (closing) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(q);
        else if (m_drops < 255) m_drops++;
      end
      m_prev_le = le;
    end
  end

  function automatic int exp_ovf();
`ifdef LATCH_CLOSE_CAPTURE_OVF_CNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(posedge ck) begin
    #1;
    if (model_on) begin
      check("out_valid", 32'(out_valid), 32'(m_fifo.size() > 0));
      check("empty",     32'(empty),     32'(m_fifo.size() == 0));
      check("full",      32'(full),      32'(m_fifo.size() == DEPTH));
      check("ovf_cnt",   32'(ovf_cnt),   32'(exp_ovf()));
      if (m_fifo.size() > 0) check("out_data", 32'(out_data), 32'(m_fifo[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic l, input logic [WIDTH-1:0] d,
                     input logic r);
    @(negedge ck);
    rst       = 1'b0;
    le        = l;
    q         = d;
    out_ready = r;
    @(posedge ck);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] drain_exp [4];
    drain_exp = '{8'd2, 8'd3, 8'd4, 8'd9};

    // Reset with le held high through release.
    repeat (2) @(posedge ck);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_ovf",       32'(ovf_cnt),   32'd0);

    // Single close: the release edge with le=1 is not a close.
    cyc(1'b1, 8'h00, 1'b0);
    check("release_no_push", 32'(empty), 32'd1);
    cyc(1'b0, 8'hA5, 1'b0);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'hA5);
    check("single_empty", 32'(empty),     32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    check("single_drained", 32'(empty), 32'd1);
    // out_ready while empty: nothing happens.
    cyc(1'b0, 8'h00, 1'b1);
    check("ready_on_empty", 32'(empty), 32'd1);

    // Fill and overflow: five closes, q = 1..5.
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 8'h00, 1'b0);
      cyc(1'b0, 8'(k), 1'b0);
      if (k == 4) check("fill_full", 32'(full), 32'd1);
    end
    check("ovf_full",  32'(full),     32'd1);
    check("ovf_head",  32'(out_data), 32'd1);
`ifdef LATCH_CLOSE_CAPTURE_OVF_CNT_EN
    check("ovf_count", 32'(ovf_cnt),  32'd1);
`else
    check("ovf_count", 32'(ovf_cnt),  32'd0);
`endif

    // Simultaneous push and pop while full.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'h09, 1'b1);
    check("pp_head", 32'(out_data), 32'd2);
    check("pp_full", 32'(full),     32'd1);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 32'(out_data), 32'(drain_exp[i]));
      cyc(1'b0, 8'h00, 1'b1);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Wrap-around: ten push/pop pairs, q = 0..9.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'h00, 1'b0);
      cyc(1'b0, 8'(i), 1'b0);
      check("wrap_data", 32'(out_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1);
    end
    check("wrap_empty", 32'(empty), 32'd1);

    // Reset mid-operation with a coincident close.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 8'h00, 1'b0);
      cyc(1'b0, 8'(8'h40 + k), 1'b0);
    end
    cyc(1'b1, 8'h00, 1'b0);
    @(negedge ck);
    rst = 1'b1; le = 1'b0; q = 8'h77; out_ready = 1'b1;
    @(posedge ck);
    #2;
    check("midrst_empty", 32'(empty),     32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ovf",   32'(ovf_cnt),   32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    check("midrst_no_capture", 32'(empty), 32'd1);

    // le held high for 20 cycles with q toggling, then one close.
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i * 7), 1'b0);
    check("le_high_no_push", 32'(empty), 32'd1);
    cyc(1'b0, 8'h3C, 1'b0);
    check("le_fall_data",  32'(out_data),  32'h3C);
    check("le_fall_valid", 32'(out_valid), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("le_fall_one_entry", 32'(empty), 32'd1);

    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
